// File: rtl/seg_scan_if.sv
// Update stream from the seven-segment bus monitor to its consumer.
// The decoder drives the master modport. The consumer drives out_ready.
interface seg_scan_if #(
   parameter int IDX_W = 2
) ();
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic [3:0]       out_value;
   logic [1:0]       out_code;

   modport master (
      output out_valid,
      output out_idx,
      output out_value,
      output out_code,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_idx,
      input  out_value,
      input  out_code,
      output out_ready
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment bus monitor.
// It samples the multiplexed segment/select lines and waits for a stable
// sample. It decodes each position's glyph into a per-position table and
// streams every change of content out through a valid/ready interface.
// Optional build macro SEG_SCAN_DIGIT89_EN adds decoding of the 8 and 9 glyphs.
// Without it, both of those glyphs decode as invalid.
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int IDX_W         = 2,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_in,
   input  logic [NUM_DIGITS-1:0] sel_in,
   seg_scan_if.master            out_bus,
   output logic                  err_sel
);
   localparam int SW = NUM_DIGITS + 7;
   localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
   localparam logic [3:0] STABLE_PRE = 4'(STABLE_CYCLES - 1);
   localparam logic [1:0] CODE_DIGIT   = 2'b00;
   localparam logic [1:0] CODE_BLANK   = 2'b01;
   localparam logic [1:0] CODE_INVALID = 2'b10;
   localparam logic [1:0] CODE_UNKNOWN = 2'b11;
   localparam logic [NUM_DIGITS-1:0] SEL_ZERO = {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Glyph decode, returned as {code, value}.
   function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'b1111110: r = {CODE_DIGIT, 4'd0};
         7'b0110000: r = {CODE_DIGIT, 4'd1};
         7'b1101101: r = {CODE_DIGIT, 4'd2};
         7'b1111001: r = {CODE_DIGIT, 4'd3};
         7'b0110011: r = {CODE_DIGIT, 4'd4};
         7'b1011011: r = {CODE_DIGIT, 4'd5};
         7'b1011111: r = {CODE_DIGIT, 4'd6};
         7'b1110000: r = {CODE_DIGIT, 4'd7};
`ifdef SEG_SCAN_DIGIT89_EN
         7'b1111111: r = {CODE_DIGIT, 4'd8};
         7'b1111011: r = {CODE_DIGIT, 4'd9};
`endif
         7'b0000000: r = {CODE_BLANK, 4'd0};
         default:    r = {CODE_INVALID, 4'd0};
      endcase
      return r;
   endfunction

   logic [SW-1:0]         sync1_r, sync2_r, held_r;
   logic [3:0]            cnt_r;
   logic [5:0]            entry_r [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dirty_r;
   state_t                state_r, state_nx_s;
   logic                  out_valid_r;
   logic [IDX_W-1:0]      out_idx_r;
   logic [3:0]            out_value_r;
   logic [1:0]            out_code_r;
   logic                  err_sel_r;

   logic [NUM_DIGITS-1:0] sel_s;
   logic [6:0]            seg_s;
   logic                  accept_s, sel_zero_s, sel_multi_s, wr_s;
   logic [5:0]            decoded_s;
   logic [IDX_W-1:0]      wr_idx_s, pick_idx_s;
   logic                  any_dirty_s, load_s, done_s;

   assign sel_s       = sync2_r[SW-1:7];
   assign seg_s       = sync2_r[6:0];
   assign sel_zero_s  = (sel_s == SEL_ZERO);
   assign sel_multi_s = ((sel_s & (sel_s - SEL_ONE)) != SEL_ZERO);
   assign accept_s    = (sync2_r == held_r) && (cnt_r == STABLE_PRE);
   assign decoded_s   = decode_glyph(seg_s);
   assign any_dirty_s = (dirty_r != SEL_ZERO);

   // Two-flop synchronizer, previous-sample hold and stability counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= {SW{1'b0}};
         sync2_r <= {SW{1'b0}};
         held_r  <= {SW{1'b0}};
         cnt_r   <= 4'd0;
      end else begin
         sync1_r <= {sel_in, seg_in};
         sync2_r <= sync1_r;
         held_r  <= sync2_r;
         if (sync2_r != held_r) begin
            cnt_r <= 4'd1;
         end else if (cnt_r != STABLE_MAX) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Encode the one-hot select and decide whether the table entry changes.
   always_comb begin
      wr_idx_s = {IDX_W{1'b0}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_s[i]) begin
            wr_idx_s = IDX_W'(i);
         end else begin
            wr_idx_s = wr_idx_s;
         end
      end
      wr_s = accept_s && !sel_zero_s && !sel_multi_s &&
             (entry_r[wr_idx_s] != decoded_s);
   end

   // Lowest-index dirty position is the next one to report.
   always_comb begin
      pick_idx_s = {IDX_W{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (dirty_r[i]) begin
            pick_idx_s = IDX_W'(i);
         end else begin
            pick_idx_s = pick_idx_s;
         end
      end
   end

   // Output FSM next-state and strobe logic.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_dirty_s) begin
               load_s     = 1'b1;
               state_nx_s = PRESENT;
            end else begin
               state_nx_s = IDLE;
            end
         end
         PRESENT: begin
            if (out_valid_r && out_bus.out_ready) begin
               done_s     = 1'b1;
               state_nx_s = IDLE;
            end else begin
               state_nx_s = PRESENT;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Per-position table and dirty bits; a new write beats the dirty clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            entry_r[i] <= {CODE_UNKNOWN, 4'd0};
         end
         dirty_r <= SEL_ZERO;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_s && (wr_idx_s == IDX_W'(i))) begin
               entry_r[i] <= decoded_s;
               dirty_r[i] <= 1'b1;
            end else if (load_s && (pick_idx_s == IDX_W'(i))) begin
               dirty_r[i] <= 1'b0;
            end else begin
               dirty_r[i] <= dirty_r[i];
            end
         end
      end
   end

   // Registered update outputs plus the sticky multi-select flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_idx_r   <= {IDX_W{1'b0}};
         out_value_r <= 4'd0;
         out_code_r  <= 2'b00;
         err_sel_r   <= 1'b0;
      end else begin
         if (load_s) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= pick_idx_s;
            out_value_r <= entry_r[pick_idx_s][3:0];
            out_code_r  <= entry_r[pick_idx_s][5:4];
         end else if (done_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (accept_s && sel_multi_s) begin
            err_sel_r <= 1'b1;
         end else begin
            err_sel_r <= err_sel_r;
         end
      end
   end

   assign out_bus.out_valid = out_valid_r;
   assign out_bus.out_idx   = out_idx_r;
   assign out_bus.out_value = out_value_r;
   assign out_bus.out_code  = out_code_r;
   assign err_sel           = err_sel_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: latency, scan ordering with bubbles,
// glitch rejection, multi-select flag, 8/9 glyph option and mid-handshake reset.
module tb_seg_scan_decoder;
   logic       clk;
   logic       rst_n;
   logic [6:0] seg;
   logic [3:0] sel;
   logic       err_sel;

   int n_checks = 0;
   int n_pass   = 0;

   seg_scan_if #(.IDX_W(2)) bus ();

   seg_scan_decoder #(
      .NUM_DIGITS(4),
      .IDX_W(2),
      .STABLE_CYCLES(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .seg_in(seg),
      .sel_in(sel),
      .out_bus(bus),
      .err_sel(err_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // examine, then clock, n times; count accepted updates and keep the last one
   task automatic run_count(input int n, output int cnt,
                            output logic [1:0] idx, output logic [3:0] val,
                            output logic [1:0] code);
      cnt = 0; idx = 2'd0; val = 4'd0; code = 2'd0;
      for (int k = 0; k < n; k++) begin
         if (bus.out_valid && bus.out_ready) begin
            cnt++;
            idx  = bus.out_idx;
            val  = bus.out_value;
            code = bus.out_code;
         end
         tick();
      end
   endtask

   logic [6:0] scan_seg [4];
   logic [3:0] exp_val  [4];
   logic [1:0] exp_code [4];

   initial begin
      int         cnt;
      logic [1:0] idx;
      logic [3:0] val;
      logic [1:0] code;
      int         got_n;
      logic       prev_v;
      logic [3:0] exp9_val;
      logic [1:0] exp9_code;

      scan_seg[0] = 7'b1111001; exp_val[0] = 4'd3; exp_code[0] = 2'b00;
      scan_seg[1] = 7'b1111110; exp_val[1] = 4'd0; exp_code[1] = 2'b00;
      scan_seg[2] = 7'b0000000; exp_val[2] = 4'd0; exp_code[2] = 2'b01;
      scan_seg[3] = 7'b1011111; exp_val[3] = 4'd6; exp_code[3] = 2'b00;

      // ---- reset ----
      rst_n = 1'b0; sel = 4'b0000; seg = 7'b0000000; bus.out_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_idx",   {30'd0, bus.out_idx},   32'd0);
      chk("rst_value", {28'd0, bus.out_value}, 32'd0);
      chk("rst_code",  {30'd0, bus.out_code},  32'd0);
      chk("rst_err",   {31'd0, err_sel},       32'd0);

      // ---- single digit, latency STABLE_CYCLES+3 = 6 edges ----
      rst_n = 1'b1; sel = 4'b0001; seg = 7'b1101101;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) chk("lat_e5_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      chk("lat_e6_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("lat_idx",   {30'd0, bus.out_idx},   32'd0);
      chk("lat_value", {28'd0, bus.out_value}, 32'd2);
      chk("lat_code",  {30'd0, bus.out_code},  32'd0);
      run_count(10, cnt, idx, val, code);
      chk("const_updates", cnt, 32'd1);

      // ---- scan four positions with consumer stalled ----
      bus.out_ready = 1'b0;
      for (int p = 0; p < 4; p++) begin
         sel = 4'b0001 << p;
         seg = scan_seg[p];
         for (int k = 0; k < 5; k++) tick();
      end
      sel = 4'b0000; seg = 7'b0000000;
      run_count(6, cnt, idx, val, code);
      chk("scan_stalled", cnt, 32'd0);
      bus.out_ready = 1'b1;
      got_n = 0; prev_v = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (bus.out_valid) begin
            chk("scan_bubble", {31'd0, prev_v}, 32'd0);
            if (got_n < 4) begin
               chk("scan_idx",   {30'd0, bus.out_idx},   got_n);
               chk("scan_value", {28'd0, bus.out_value}, {28'd0, exp_val[got_n]});
               chk("scan_code",  {30'd0, bus.out_code},  {30'd0, exp_code[got_n]});
            end
            got_n++;
         end
         prev_v = bus.out_valid;
         tick();
      end
      chk("scan_count", got_n, 32'd4);

      // ---- glitch rejection ----
      sel = 4'b0010; seg = 7'b0110000;
      run_count(12, cnt, idx, val, code);
      chk("gl_setup_cnt", cnt, 32'd1);
      chk("gl_setup_val", {28'd0, val}, 32'd1);
      seg = 7'b1111111;
      tick(); tick();
      seg = 7'b0110000;
      run_count(12, cnt, idx, val, code);
      chk("glitch_updates", cnt, 32'd0);

      // ---- multi-hot select ----
      sel = 4'b0011; seg = 7'b1011011;
      run_count(8, cnt, idx, val, code);
      chk("multi_updates", cnt, 32'd0);
      chk("multi_err", {31'd0, err_sel}, 32'd1);
      sel = 4'b0000; seg = 7'b0000000;
      run_count(8, cnt, idx, val, code);
      chk("multi_err_sticky", {31'd0, err_sel}, 32'd1);

      // ---- 9 glyph, build dependent ----
`ifdef SEG_SCAN_DIGIT89_EN
      exp9_val = 4'd9; exp9_code = 2'b00;
`else
      exp9_val = 4'd0; exp9_code = 2'b10;
`endif
      sel = 4'b0100; seg = 7'b1111011;
      run_count(10, cnt, idx, val, code);
      chk("g9_cnt",   cnt, 32'd1);
      chk("g9_idx",   {30'd0, idx},  32'd2);
      chk("g9_value", {28'd0, val},  {28'd0, exp9_val});
      chk("g9_code",  {30'd0, code}, {30'd0, exp9_code});

      // ---- reset while an update is presented ----
      bus.out_ready = 1'b0;
      sel = 4'b1000; seg = 7'b1111110;
      for (int k = 0; k < 20 && !bus.out_valid; k++) tick();
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_idx",   {30'd0, bus.out_idx},   32'd0);
      chk("mid_rst_value", {28'd0, bus.out_value}, 32'd0);
      chk("mid_rst_code",  {30'd0, bus.out_code},  32'd0);
      chk("mid_rst_err",   {31'd0, err_sel},       32'd0);
      rst_n = 1'b1; bus.out_ready = 1'b1;
      run_count(12, cnt, idx, val, code);
      chk("reemit_cnt",   cnt, 32'd1);
      chk("reemit_idx",   {30'd0, idx},  32'd3);
      chk("reemit_value", {28'd0, val},  32'd0);
      chk("reemit_code",  {30'd0, code}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
